// File: rtl/arb_mux_n_pkg.sv
// ----------------------------------------------------------------------------
// arb_mux_n_pkg
// Shared bus-width constants and helpers for the N-channel arbiter/mux slice.
//   ADDRESS_BUS_WIDTH : default address width of one beat
//   DATA_BUS_WIDTH    : default data width of one beat
//   MAX_ARB_CH        : largest channel count the arbiter is meant to serve
//   lock_state_e      : grant-lock state used when ARB_MUX_LOCK_EN is defined
//   sel_width()       : grant index width for a given channel count (min 1)
// ----------------------------------------------------------------------------
package arb_mux_n_pkg;

   localparam int ADDRESS_BUS_WIDTH = 32;
   localparam int DATA_BUS_WIDTH    = 32;
   localparam int MAX_ARB_CH        = 16;

   typedef enum logic {
      LOCK_OPEN = 1'b0,
      LOCK_HELD = 1'b1
   } lock_state_e;

   // A single channel still needs a 1-bit index so ports never collapse to zero width.
   function automatic int sel_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/arb_mux_n_rr_arbiter.sv
// ----------------------------------------------------------------------------
// rr_arbiter
// Combinational round-robin priority search. Starting just after the last
// granted channel (ptr) and wrapping at NUM_CH-1 -> 0, the first requesting
// channel wins. Works for any NUM_CH, including non-power-of-2 counts.
// Ports:
//   req          in  NUM_CH  eligible requests
//   ptr          in  SEL_W   index of the most recently granted channel
//   grant_onehot out NUM_CH  one-hot winner, zero when nobody requests
//   grant_idx    out SEL_W   binary winner index, zero when nobody requests
// ----------------------------------------------------------------------------
module rr_arbiter
   import arb_mux_n_pkg::*;
#(
   parameter int NUM_CH = 4,
   parameter int SEL_W  = sel_width(NUM_CH)
) (
   input  logic [NUM_CH-1:0] req,
   input  logic [SEL_W-1:0]  ptr,
   output logic [NUM_CH-1:0] grant_onehot,
   output logic [SEL_W-1:0]  grant_idx
);

   // Two passes instead of a rotate: first the channels above ptr, then the
   // wrapped channels at or below ptr. This keeps every index a loop constant
   // and wraps cleanly for non-power-of-2 NUM_CH.
   always_comb begin
      logic found;
      found        = 1'b0;
      grant_onehot = '0;
      grant_idx    = '0;
      for (int i = 0; i < NUM_CH; i++) begin
         if (!found && req[i] && (i > int'(ptr))) begin
            found           = 1'b1;
            grant_onehot[i] = 1'b1;
            grant_idx       = SEL_W'(i);
         end
      end
      for (int i = 0; i < NUM_CH; i++) begin
         if (!found && req[i] && (i <= int'(ptr))) begin
            found           = 1'b1;
            grant_onehot[i] = 1'b1;
            grant_idx       = SEL_W'(i);
         end
      end
   end

endmodule

// File: rtl/arb_mux_n.sv
// ----------------------------------------------------------------------------
// arb_mux_n
// N-channel round-robin arbiter with a 1-deep registered output mux for
// address+data beats. Sits between several bus masters and one bus port.
// Optional feature: define ARB_MUX_LOCK_EN to add req_lock, which lets a
// channel hold the grant across several beats.
// Ports:
//   clk, rst_n    clock, asynchronous active-low reset
//   req_valid     in  NUM_CH     per-channel beat valid
//   req_ready     out NUM_CH     per-channel accept, one-hot or zero
//   req_addr      in  NUM_CH*AW  channel i at [i*AW +: AW]
//   req_data      in  NUM_CH*DW  channel i at [i*DW +: DW]
//   req_lock      in  NUM_CH     hold-grant request (ARB_MUX_LOCK_EN only)
//   out_valid     out 1          output register holds a beat
//   out_ready     in  1          downstream accepts the beat
//   out_addr      out AW         registered address
//   out_data      out DW         registered data
//   out_grant     out SEL_W      source channel of the registered beat
// ----------------------------------------------------------------------------
module arb_mux_n
   import arb_mux_n_pkg::*;
#(
   parameter int NUM_CH = 4,
   parameter int AW     = ADDRESS_BUS_WIDTH,
   parameter int DW     = DATA_BUS_WIDTH,
   parameter int SEL_W  = sel_width(NUM_CH)
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic [NUM_CH-1:0]    req_valid,
   output logic [NUM_CH-1:0]    req_ready,
   input  logic [NUM_CH*AW-1:0] req_addr,
   input  logic [NUM_CH*DW-1:0] req_data,
`ifdef ARB_MUX_LOCK_EN
   input  logic [NUM_CH-1:0]    req_lock,
`endif
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [AW-1:0]        out_addr,
   output logic [DW-1:0]        out_data,
   output logic [SEL_W-1:0]     out_grant
);

   logic [SEL_W-1:0]  rr_ptr_q, rr_ptr_d;
   logic              out_valid_q, out_valid_d;
   logic [AW-1:0]     out_addr_q, out_addr_d;
   logic [DW-1:0]     out_data_q, out_data_d;
   logic [SEL_W-1:0]  out_grant_q, out_grant_d;
   logic [NUM_CH-1:0] eligible;
   logic [NUM_CH-1:0] win_onehot;
   logic [SEL_W-1:0]  win_idx;
   logic [AW-1:0]     mux_addr;
   logic [DW-1:0]     mux_data;
   logic              load_en;
   logic              xfer;

   // rst_n is folded in so no channel sees an accept while reset is held.
   assign load_en = rst_n && (!out_valid_q || out_ready);

`ifdef ARB_MUX_LOCK_EN
   lock_state_e      lock_q, lock_d;
   logic [SEL_W-1:0] lock_owner_q, lock_owner_d;

   // While locked only the owner may compete, even when it is idle.
   assign eligible = (lock_q == LOCK_HELD) ?
                     (req_valid & (NUM_CH'(1) << lock_owner_q)) : req_valid;
`else
   assign eligible = req_valid;
`endif

   rr_arbiter #(
      .NUM_CH (NUM_CH),
      .SEL_W  (SEL_W)
   ) u_rr_arbiter (
      .req          (eligible),
      .ptr          (rr_ptr_q),
      .grant_onehot (win_onehot),
      .grant_idx    (win_idx)
   );

   assign req_ready = load_en ? win_onehot : '0;
   assign xfer      = |req_ready;

   // One-hot AND-OR slice mux of the winning channel's address and data.
   always_comb begin
      mux_addr = '0;
      mux_data = '0;
      for (int i = 0; i < NUM_CH; i++) begin
         if (win_onehot[i]) begin
            mux_addr = req_addr[i*AW +: AW];
            mux_data = req_data[i*DW +: DW];
         end
      end
   end

   // Output register and pointer: load on transfer, drop valid on a bare
   // drain (fields hold), freeze everything on a stall.
   always_comb begin
      rr_ptr_d    = rr_ptr_q;
      out_valid_d = out_valid_q;
      out_addr_d  = out_addr_q;
      out_data_d  = out_data_q;
      out_grant_d = out_grant_q;
      if (xfer) begin
         rr_ptr_d    = win_idx;
         out_valid_d = 1'b1;
         out_addr_d  = mux_addr;
         out_data_d  = mux_data;
         out_grant_d = win_idx;
      end else if (out_ready) begin
         out_valid_d = 1'b0;
      end
   end

`ifdef ARB_MUX_LOCK_EN
   // Any transfer while locked comes from the owner, so a transfer without
   // req_lock always leaves the lock open.
   always_comb begin
      lock_d       = lock_q;
      lock_owner_d = lock_owner_q;
      if (xfer) begin
         if (|(req_lock & win_onehot)) begin
            lock_d       = LOCK_HELD;
            lock_owner_d = win_idx;
         end else begin
            lock_d = LOCK_OPEN;
         end
      end
   end
`endif

   // rr_ptr resets to the last channel so channel 0 has first priority.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rr_ptr_q     <= SEL_W'(NUM_CH - 1);
         out_valid_q  <= 1'b0;
         out_addr_q   <= '0;
         out_data_q   <= '0;
         out_grant_q  <= '0;
`ifdef ARB_MUX_LOCK_EN
         lock_q       <= LOCK_OPEN;
         lock_owner_q <= '0;
`endif
      end else begin
         rr_ptr_q     <= rr_ptr_d;
         out_valid_q  <= out_valid_d;
         out_addr_q   <= out_addr_d;
         out_data_q   <= out_data_d;
         out_grant_q  <= out_grant_d;
`ifdef ARB_MUX_LOCK_EN
         lock_q       <= lock_d;
         lock_owner_q <= lock_owner_d;
`endif
      end
   end

   assign out_valid = out_valid_q;
   assign out_addr  = out_addr_q;
   assign out_data  = out_data_q;
   assign out_grant = out_grant_q;

endmodule
